// File: rtl/div_pkg.sv
// Shared definitions for the sequential 8-bit divider.
// Holds the FSM state encoding and the number of quotient iterations.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One quotient bit is produced per CALC cycle, so this equals the operand width.
  localparam int DIV_ITER = 8;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/sub_8_bit.sv
// 8-bit subtractor with borrow in and borrow out.
// Ports:
//   a, b : minuend and subtrahend
//   cin  : borrow in
//   sub  : a - b - cin, modulo 256
//   out  : borrow out, 1 when a < b + cin
module sub_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sub,
  output logic       out
);

  logic [8:0] diff_s;

  // A 9-bit subtraction leaves the borrow in the top bit.
  always_comb begin
    diff_s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
  end

  assign sub = diff_s[7:0];
  assign out = diff_s[8];

endmodule

// File: rtl/div_8_bit_seq.sv
// Sequential 8-bit unsigned restoring divider.
// It produces one quotient bit per cycle, MSB first. A single sub_8_bit
// compares the shifted partial remainder against the divisor.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   start             : request a division; only accepted in IDLE
//   dividend, divisor : operands, captured on the accepted start
//   busy              : high while the iterations run
//   done              : one-cycle pulse when the results become valid
//   quotient          : result, held until the next completed division
//   remainder         : result, held until the next completed division
//   div_by_zero       : set with done when the divisor was zero
module div_8_bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_reg_q, q_reg_d;
  logic [WIDTH-1:0]   d_reg_q, d_reg_d;
  logic [WIDTH-1:0]   r_reg_q, r_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   sub_a_s;
  logic               msb_s;
  logic [WIDTH-1:0]   diff_s;
  logic               borrow_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   r_next_s;
  logic [WIDTH-1:0]   q_next_s;

  // Shift the next dividend bit into the partial remainder. Bit 7 of the
  // remainder that falls out becomes the 9th bit of the shifted value.
  always_comb begin
    sub_a_s = {r_reg_q[WIDTH-2:0], q_reg_q[WIDTH-1]};
    msb_s   = r_reg_q[WIDTH-1];
  end

  sub_8_bit u_sub (
    .a   (sub_a_s),
    .b   (d_reg_q),
    .cin (1'b0),
    .sub (diff_s),
    .out (borrow_s)
  );

  // When msb is set, the 9-bit value is at least 256 and exceeds any divisor,
  // so the subtraction always succeeds. Its mod-256 result is then still exact.
  always_comb begin
    qbit_s   = msb_s | ~borrow_s;
    r_next_s = qbit_s ? diff_s : sub_a_s;
    q_next_s = {q_reg_q[WIDTH-2:0], qbit_s};
  end

  // Next-state and output decode for the IDLE -> CALC -> DONE -> IDLE sequence.
  always_comb begin
    state_d     = state_q;
    q_reg_d     = q_reg_q;
    d_reg_d     = d_reg_q;
    r_reg_d     = r_reg_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            q_reg_d = dividend;
            d_reg_d = divisor;
            r_reg_d = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end else begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        q_reg_d = q_next_s;
        r_reg_d = r_next_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          quotient_d  = q_next_s;
          remainder_d = r_next_s;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      q_reg_q     <= {WIDTH{1'b0}};
      d_reg_q     <= {WIDTH{1'b0}};
      r_reg_q     <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_reg_q     <= q_reg_d;
      d_reg_q     <= d_reg_d;
      r_reg_q     <= r_reg_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
